// File: rtl/square_pkg.sv
//------------------------------------------------------------------------------
// square_pkg
//   Shared types and constants for the squarer sum-of-squares frame stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package square_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int SQ_W   = 6;
  localparam int SQ_MAX = 49;
  localparam int CNT_W  = 8;

endpackage

`default_nettype wire

// File: rtl/square_accumulator_sat_add.sv
//------------------------------------------------------------------------------
// sat_add
//   Unsigned add of a 6-bit square into an ACC_W accumulator, clamped at all-ones.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sat_add
  import square_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [SQ_W-1:0]  sq,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  logic [ACC_W:0] wide;

  // One extra bit catches the carry-out that signals overflow.
  assign wide = {1'b0, acc} + {{(ACC_W + 1 - SQ_W){1'b0}}, sq};
  assign sat  = wide[ACC_W];
  assign sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

`default_nettype wire

// File: rtl/square_accumulator.sv
//------------------------------------------------------------------------------
// square_accumulator
//   Frame-based saturating sum of squares with valid/ready in and held result out.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module square_accumulator
  import square_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SQ_W-1:0]   in_sq,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t             state_q;
  state_t             state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sticky_q;
  logic [ACC_W-1:0]   sum_w;
  logic               sat_w;
  logic               accept;
  logic               close;

  sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc (acc_q),
    .sq  (in_sq),
    .sum (sum_w),
    .sat (sat_w)
  );

  // Ready and valid decode straight from the state register, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign close     = accept & ((cnt_q == LAST_IDX) | in_last);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (close)     state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default:                state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (accept) begin
      if (close) begin
        out_sum   <= sum_w;
        out_count <= cnt_q + CNT_W'(1);
        out_sat   <= sticky_q | sat_w;
        acc_q     <= '0;
        cnt_q     <= '0;
        sticky_q  <= 1'b0;
      end else begin
        acc_q     <= sum_w;
        cnt_q     <= cnt_q + CNT_W'(1);
        sticky_q  <= sticky_q | sat_w;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_square_accumulator.sv
//------------------------------------------------------------------------------
// tb_square_accumulator
//   Table vectors, hand-written corner sequences and randomized frames vs a model.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_square_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [2];
  logic       in_last   [2];
  logic       out_ready [2];
  logic [5:0] in_sq     [2];

  logic        in_ready0, in_ready1, out_valid0, out_valid1, sat0, sat1;
  logic [11:0] sum0;
  logic [5:0]  sum1;
  logic [7:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  square_accumulator #(.FRAME_LEN(8), .ACC_W(12)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready0),
    .in_sq(in_sq[0]), .in_last(in_last[0]), .out_valid(out_valid0),
    .out_ready(out_ready[0]), .out_sum(sum0), .out_count(cnt0), .out_sat(sat0));

  square_accumulator #(.FRAME_LEN(4), .ACC_W(6)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready1),
    .in_sq(in_sq[1]), .in_last(in_last[1]), .out_valid(out_valid1),
    .out_ready(out_ready[1]), .out_sum(sum1), .out_count(cnt1), .out_sat(sat1));

  typedef struct { int w; int sum; int cnt; int sat; } res_t;
  typedef struct { int w; int n; int s[8]; bit last; int e_sum; int e_cnt; int e_sat; } vec_t;

  int   FL [2] = '{8, 4};
  int   MX [2] = '{4095, 63};
  int   n_chk = 0;
  int   n_fail = 0;
  res_t gotq[$];
  res_t expq[$];
  int   msum [2] = '{0, 0};
  int   mcnt [2] = '{0, 0};
  int   frames_closed = 0;
  bit   rand_or = 1'b0;
  bit   pv_hold [2] = '{1'b0, 1'b0};
  int   psum [2], pcnt [2], psat [2];
  int   low_cnt [2] = '{0, 0};
  vec_t tbl [9];

  function automatic int rdy(int w);  return (w == 0) ? int'(in_ready0)  : int'(in_ready1);  endfunction
  function automatic int vld(int w);  return (w == 0) ? int'(out_valid0) : int'(out_valid1); endfunction
  function automatic int osum(int w); return (w == 0) ? int'(sum0) : int'(sum1); endfunction
  function automatic int ocnt(int w); return (w == 0) ? int'(cnt0) : int'(cnt1); endfunction
  function automatic int osat(int w); return (w == 0) ? int'(sat0) : int'(sat1); endfunction

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a frame is just the plain sum of its samples, clamped; sat means the sum exceeded the max.
  function automatic void model_accept(input int w, input int sq, input bit last);
    res_t e;
    msum[w] += sq;
    mcnt[w]++;
    if (mcnt[w] == FL[w] || last) begin
      e.w   = w;
      e.sum = (msum[w] > MX[w]) ? MX[w] : msum[w];
      e.cnt = mcnt[w];
      e.sat = (msum[w] > MX[w]) ? 1 : 0;
      expq.push_back(e);
      frames_closed++;
      msum[w] = 0;
      mcnt[w] = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      pv_hold[0] = 1'b0;
      pv_hold[1] = 1'b0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        res_t r;
        if (pv_hold[w]) begin
          chk("stall_valid", vld(w), 1);
          chk("stall_sum", osum(w), psum[w]);
          chk("stall_count", ocnt(w), pcnt[w]);
          chk("stall_sat", osat(w), psat[w]);
        end
        if (vld(w) != 0) chk("ready_in_hold", rdy(w), 0);
        if (rdy(w) == 0) low_cnt[w]++;
        if (vld(w) != 0 && out_ready[w]) begin
          r.w = w; r.sum = osum(w); r.cnt = ocnt(w); r.sat = osat(w);
          gotq.push_back(r);
        end
        pv_hold[w] = (vld(w) != 0) && !out_ready[w];
        psum[w] = osum(w);
        pcnt[w] = ocnt(w);
        psat[w] = osat(w);
      end
    end
  end

  task automatic rand_ready();
    if (rand_or) begin
      out_ready[0] = ($urandom % 3) != 0;
      out_ready[1] = ($urandom % 3) != 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rand_ready();
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the sample.
  task automatic push(input int w, input int sq, input bit last);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    in_valid[w] = 1'b1;
    in_sq[w]    = 6'(sq);
    in_last[w]  = last;
    while (!done) begin
      @(negedge clk);
      if (rdy(w) != 0) begin
        model_accept(w, sq, last);
        done = 1'b1;
      end else if (t > 200) begin
        chk("push_timeout", 0, 1);
        done = 1'b1;
      end else begin
        t++;
        @(posedge clk); #1;
        rand_ready();
      end
    end
    @(posedge clk); #1;
    in_valid[w] = 1'b0;
    in_last[w]  = 1'b0;
    rand_ready();
  endtask

  task automatic wait_results(input int n);
    int t;
    t = 0;
    while (gotq.size() < n && t < 300) begin
      idle(1);
      t++;
    end
    if (gotq.size() < n) chk("result_timeout", gotq.size(), n);
  endtask

  task automatic compare_model();
    res_t g, e;
    wait_results(expq.size());
    chk("result_total", gotq.size(), expq.size());
    while (expq.size() > 0 && gotq.size() > 0) begin
      g = gotq.pop_front();
      e = expq.pop_front();
      chk("model_dut", g.w, e.w);
      chk("model_sum", g.sum, e.sum);
      chk("model_count", g.cnt, e.cnt);
      chk("model_sat", g.sat, e.sat);
    end
    gotq.delete();
    expq.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   sq;

    tbl[0] = '{w:0, n:8, s:'{49,49,49,49,49,49,49,49}, last:0, e_sum:392, e_cnt:8, e_sat:0};
    tbl[1] = '{w:0, n:3, s:'{4,9,16,0,0,0,0,0},        last:1, e_sum:29,  e_cnt:3, e_sat:0};
    tbl[2] = '{w:0, n:2, s:'{1,1,0,0,0,0,0,0},         last:1, e_sum:2,   e_cnt:2, e_sat:0};
    tbl[3] = '{w:0, n:8, s:'{63,63,63,63,63,63,63,63}, last:0, e_sum:504, e_cnt:8, e_sat:0};
    tbl[4] = '{w:1, n:4, s:'{25,25,25,0,0,0,0,0},      last:0, e_sum:63,  e_cnt:4, e_sat:1};
    tbl[5] = '{w:1, n:4, s:'{1,1,1,1,0,0,0,0},         last:0, e_sum:4,   e_cnt:4, e_sat:0};
    tbl[6] = '{w:1, n:2, s:'{31,32,0,0,0,0,0,0},       last:1, e_sum:63,  e_cnt:2, e_sat:0};
    tbl[7] = '{w:1, n:4, s:'{63,1,0,0,0,0,0,0},        last:0, e_sum:63,  e_cnt:4, e_sat:1};
    tbl[8] = '{w:1, n:4, s:'{2,2,2,2,0,0,0,0},         last:1, e_sum:8,   e_cnt:4, e_sat:0};

    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin
      in_valid[w] = 1'b0; in_last[w] = 1'b0; in_sq[w] = '0; out_ready[w] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready0", int'(in_ready0), 1);
    chk("rst_out_valid0", int'(out_valid0), 0);
    chk("rst_sum0", int'(sum0), 0);
    chk("rst_count0", int'(cnt0), 0);
    chk("rst_sat0", int'(sat0), 0);
    chk("rst_in_ready1", int'(in_ready1), 1);
    chk("rst_out_valid1", int'(out_valid1), 0);
    chk("rst_sum1", int'(sum1), 0);
    chk("rst_count1", int'(cnt1), 0);
    chk("rst_sat1", int'(sat1), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      gotq.delete();
      expq.delete();
      low_cnt[tbl[i].w] = 0;
      for (int k = 0; k < tbl[i].n; k++)
        push(tbl[i].w, tbl[i].s[k], tbl[i].last && (k == tbl[i].n - 1));
      wait_results(1);
      idle(3);
      chk("tbl_frames", gotq.size(), 1);
      chk("tbl_ready_low_cycles", low_cnt[tbl[i].w], 1);
      if (gotq.size() > 0) begin
        r = gotq.pop_front();
        chk("tbl_sum", r.sum, tbl[i].e_sum);
        chk("tbl_count", r.cnt, tbl[i].e_cnt);
        chk("tbl_sat", r.sat, tbl[i].e_sat);
      end
    end
    gotq.delete();
    expq.delete();

    // Backpressure: result 36 held for 10 cycles while upstream keeps offering a sample.
    out_ready[0] = 1'b0;
    push(0, 36, 1'b1);
    in_valid[0] = 1'b1; in_sq[0] = 6'd5; in_last[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready0), 0);
      chk("bp_out_valid", int'(out_valid0), 1);
      chk("bp_sum", int'(sum0), 36);
      chk("bp_count", int'(cnt0), 1);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_ready", int'(in_ready0), 1);
    chk("bp_release_valid", int'(out_valid0), 0);
    model_accept(0, 5, 1'b1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    wait_results(2);
    if (gotq.size() > 0) chk("bp_first_sum", gotq[0].sum, 36);
    compare_model();

    // Asynchronous reset between edges discards a partial frame.
    push(0, 9, 1'b0);
    push(0, 9, 1'b0);
    #2 rst = 1'b1;
    #1 chk("midrst_valid", int'(out_valid0), 0);
    chk("midrst_ready", int'(in_ready0), 1);
    rst = 1'b0;
    msum[0] = 0; mcnt[0] = 0; msum[1] = 0; mcnt[1] = 0;
    expq.delete();
    gotq.delete();
    @(posedge clk); #1;
    repeat (8) push(0, 1, 1'b0);
    wait_results(1);
    if (gotq.size() > 0) begin
      chk("midrst_sum", gotq[0].sum, 8);
      chk("midrst_count", gotq[0].cnt, 8);
    end
    compare_model();

    // Randomized gaps and backpressure, 500 frames on each instance.
    rand_or = 1'b1;
    for (int w = 0; w < 2; w++) begin
      frames_closed = 0;
      while (frames_closed < 500) begin
        if ($urandom % 4 == 0) idle($urandom_range(1, 3));
        sq = ($urandom % 8 == 0) ? int'($urandom_range(50, 63)) : int'($urandom_range(0, 49));
        push(w, sq, ($urandom % 6) == 0);
      end
    end
    rand_or = 1'b0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    compare_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/square_accumulator.md
# square_accumulator

Frame-based sum-of-squares stage that sits directly downstream of the 3-bit combinational squarer. It accepts the squarer's 6-bit result `{a,b,c,d,e,f}` with a valid/ready handshake and accumulates `FRAME_LEN` samples, or fewer if `in_last` closes the frame early. It then presents the saturated sum, the sample count and a saturation flag on a held output handshake. Typical use is energy or variance measurement over short frames of 3-bit samples.

## Interface
Parameters:
- `FRAME_LEN`, default 8: samples per full frame; legal range 1..255.
- `ACC_W`, default 12: accumulator and `out_sum` width; legal range 6..32.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_sq` carries a sample.
- `in_ready` output 1: block accepts a sample this cycle.
- `in_sq` input 6: squarer output; bit 5 = `a` … bit 0 = `f`; treated as unsigned 0..49.
- `in_last` input 1: qualified by `in_valid`; marks the final sample of a short frame.
- `out_valid` output 1: frame result is valid and held.
- `out_ready` input 1: downstream consumes the result.
- `out_sum` output `ACC_W`: saturated sum of squares for the frame.
- `out_count` output 8: number of samples in the frame, 1..`FRAME_LEN`.
- `out_sat` output 1: accumulation clamped at `2^ACC_W-1` during this frame.

## Operation
- States: `ACCUM` and `HOLD`. Reset state is `ACCUM`.
- Accept condition: `in_valid & in_ready`, where `in_ready = (state == ACCUM)`.
- `ACCUM`, on each accept:
  - `acc <= sat_add(acc, in_sq)` and `cnt <= cnt + 1`.
  - The frame closes when `cnt == FRAME_LEN-1` or `in_last == 1`.
- Frame close (same edge as the final accept):
  - `out_sum` gets the post-add saturated sum.
  - `out_count` gets `cnt + 1`.
  - `out_sat` gets the sticky saturation flag OR this cycle's saturation.
  - `acc`, `cnt` and the sticky flag clear.
  - State moves to `HOLD`.
- `HOLD`:
  - `out_valid = 1`, `in_ready = 0`.
  - Outputs are stable until `out_valid & out_ready`.
  - On that handshake: next state is `ACCUM` and `out_valid` drops.
- Saturation: the sum is computed at `ACC_W+1` bits. If bit `ACC_W` is set, the result is clamped to all-ones and the sticky flag is set. The clamp holds for every later add in the frame.
- `in_last` is ignored when `in_valid` is 0.
- `in_last` on the `FRAME_LEN`-th sample counts as a single close, never a double close.
- `in_sq` values above 49 are summed as-is; the block does not check input range.
- Reset mid-frame discards the partial frame. Reset in `HOLD` drops the pending result.

## Timing
- Reset values:
  - `in_ready = 1` (state `ACCUM`).
  - `out_valid = 0`, `out_sum = 0`, `out_count = 0`, `out_sat = 0`.
  - Internal `acc = 0`, `cnt = 0`, sticky flag = 0.
- Latency: `out_valid` rises on the clock edge that accepts the closing sample. It is visible in the following cycle.
- `in_ready` is a registered state decode, with no combinational path from `out_ready`.
- Minimum cost of the handshake:
  - `out_ready` held high gives `out_valid` for exactly 1 cycle.
  - `in_ready` returns 1 cycle after the output handshake.
  - A full frame therefore takes `FRAME_LEN` + 1 cycles at best.
- Backpressure:
  - An `out_ready` stall holds `HOLD` indefinitely with all outputs frozen.
  - Upstream sees `in_ready = 0` for the whole stall.
- `in_valid` gaps inside `ACCUM` simply pause accumulation; there is no timeout.
- `FRAME_LEN = 1`: every accepted sample closes its own frame.

## Structure
- Package `square_pkg`:
  - `state_t` enum (`ACCUM`, `HOLD`).
  - `SQ_W = 6`.
  - `SQ_MAX = 49`.
  - `CNT_W = 8`.
- Sub-module `sat_add`:
  - Parameterised `ACC_W`, purely combinational.
  - Ports: `acc` in, `sq` in (6 bits), `sum` out (`ACC_W`), `sat` out.
- Top level contains the state register, counter, sticky flag and output registers.

## Test plan
- Reset release, `FRAME_LEN = 8`, inputs 49,49,49,49,49,49,49,49 with `out_ready = 1`:
  - `out_valid` pulses 1 cycle with `out_sum = 392`, `out_count = 8`, `out_sat = 0`.
  - `in_ready` is low for exactly 1 cycle.
- Short frame, inputs 4,9,16 with `in_last` on 16:
  - `out_sum = 29`, `out_count = 3`.
  - The next frame starts from 0: inputs 1,1 with `in_last` give `out_sum = 2`.
- Backpressure:
  - Close a frame with `out_sum = 36`, then hold `out_ready = 0` for 10 cycles.
  - Outputs stay stable and `in_ready` stays 0 while `in_valid` is held 1; no sample is lost or absorbed.
  - Raising `out_ready` completes the handshake; 1 cycle later `in_ready = 1`.
- Saturation, `ACC_W = 6`, `FRAME_LEN = 4`, inputs 25,25,25,0:
  - `out_sum = 63`, `out_sat = 1`.
  - The following frame 1,1,1,1 gives `out_sum = 4`, `out_sat = 0`.
- Reset mid-frame:
  - Accept 9,9, assert `rst` asynchronously between edges, release, then feed eight 1s.
  - `out_sum = 8`, `out_count = 8`.
- Random `in_valid`/`out_ready` gaps against a reference model over 1000 frames:
  - Per-frame sum, count and sat all match.
  - `out_*` are never seen to change while `out_valid & ~out_ready`.
